logistic_scheduler: RTL and testbench

LOGISTIC_SCHEDULER -- requirements
Module: logistic_scheduler

---
 rtl/logistic_scheduler_if.sv | 26 ++
 rtl/logistic_scheduler.sv | 137 +++++++++++++
 tb/tb_logistic_scheduler.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/logistic_scheduler_if.sv
// Bus bundle for logistic_scheduler: run control, operands, read port and status.
interface logistic_scheduler_if #(
   parameter int LW = 3
);
   logic          start;
   logic [17:0]   mu;
   logic [8:0]    times;
   logic [16:0]   dzero_base;
   logic [LW-1:0] rd_lane;
   logic [16:0]   rd_x;
   logic          busy;
   logic          done;
   logic [8:0]    sweep;

   // Driver side (testbench / host)
   modport master (
      output start, mu, times, dzero_base, rd_lane,
      input  rd_x, busy, done, sweep
   );

   // Scheduler side
   modport slave (
      input  start, mu, times, dzero_base, rd_lane,
      output rd_x, busy, done, sweep
   );
endinterface

// File: rtl/logistic_scheduler.sv
// Time-multiplexed logistic map x <- mu*x*(1-x) over LANES lanes sharing
// one two-stage multiplier datapath (MUL1: x*(1-x), MUL2: scale by mu).
module logistic_scheduler #(
   parameter int LANES = 8,
   parameter int LW    = 3
) (
   input logic                CLK,
   input logic                RST,
   logistic_scheduler_if.slave bus
);

   typedef enum logic [1:0] {IDLE, LOAD, MUL1, MUL2} state_t;

   state_t        state_q, state_d;
   logic [16:0]   x_q [LANES];
   logic [16:0]   x_d [LANES];
   logic [LW-1:0] p_q, p_d;
   logic [33:0]   term_q, term_d;
   logic [17:0]   mu_q, mu_d;
   logic [8:0]    times_q, times_d;
   logic [16:0]   base_q, base_d;
   logic          busy_q, busy_d;
   logic          done_q, done_d;
   logic [8:0]    sweep_q, sweep_d;
   logic [16:0]   rd_x_q, rd_x_d;

   logic [16:0]   sel_x;
   logic [33:0]   term_calc;
   logic [16:0]   x_new;
   logic [8:0]    sweep_inc;

   // Shared datapath: first stage forms x*(2^17-x); second stage keeps the
   // top 18 bits of that product, scales by mu and takes Q0.17 result bits.
   always_comb begin
      sel_x     = x_q[p_q];
      term_calc = {17'b0, sel_x} * (34'h20000 - {17'b0, sel_x});
      x_new     = 17'(({18'b0, mu_q} * {18'b0, 18'(term_q >> 16)}) >> 17);
      sweep_inc = sweep_q + 9'd1;
   end

   // Next-state logic for the FSM, lane registers and status outputs
   always_comb begin
      state_d = state_q;
      for (int unsigned i = 0; i < LANES; i++) x_d[i] = x_q[i];
      p_d     = p_q;
      term_d  = term_q;
      mu_d    = mu_q;
      times_d = times_q;
      base_d  = base_q;
      busy_d  = busy_q;
      done_d  = done_q;
      sweep_d = sweep_q;
      rd_x_d  = x_q[bus.rd_lane];

      case (state_q)
         IDLE: begin
            if (bus.start) begin
               mu_d    = bus.mu;
               times_d = bus.times;
               base_d  = bus.dzero_base;
               done_d  = 1'b0;
               sweep_d = '0;
               busy_d  = 1'b1;
               state_d = LOAD;
            end
         end
         LOAD: begin
            for (int unsigned i = 0; i < LANES; i++) x_d[i] = base_q + 17'(i);
            p_d = '0;
            if (times_q == 9'd0) begin
               busy_d  = 1'b0;
               done_d  = 1'b1;
               state_d = IDLE;
            end else begin
               state_d = MUL1;
            end
         end
         MUL1: begin
            term_d  = term_calc;
            state_d = MUL2;
         end
         MUL2: begin
            x_d[p_q] = x_new;
            if (p_q == LW'(LANES - 1)) begin
               p_d     = '0;
               sweep_d = sweep_inc;
               if (sweep_inc == times_q) begin
                  busy_d  = 1'b0;
                  done_d  = 1'b1;
                  state_d = IDLE;
               end else begin
                  state_d = MUL1;
               end
            end else begin
               p_d     = p_q + LW'(1);
               state_d = MUL1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // State registers with synchronous active-high reset
   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q <= IDLE;
         for (int unsigned i = 0; i < LANES; i++) x_q[i] <= '0;
         p_q     <= '0;
         term_q  <= '0;
         mu_q    <= '0;
         times_q <= '0;
         base_q  <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         sweep_q <= '0;
         rd_x_q  <= '0;
      end else begin
         state_q <= state_d;
         for (int unsigned i = 0; i < LANES; i++) x_q[i] <= x_d[i];
         p_q     <= p_d;
         term_q  <= term_d;
         mu_q    <= mu_d;
         times_q <= times_d;
         base_q  <= base_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         sweep_q <= sweep_d;
         rd_x_q  <= rd_x_d;
      end
   end

   assign bus.rd_x  = rd_x_q;
   assign bus.busy  = busy_q;
   assign bus.done  = done_q;
   assign bus.sweep = sweep_q;

endmodule

// File: tb/tb_logistic_scheduler.sv
// Directed bench for logistic_scheduler with a scoreboard of golden lane values.
module tb_logistic_scheduler;

   localparam int LANES = 8;
   localparam int LW    = 3;

   logic CLK = 1'b0;
   logic RST;

   logistic_scheduler_if #(.LW(LW)) bus ();

   logistic_scheduler #(.LANES(LANES), .LW(LW)) dut (
      .CLK (CLK),
      .RST (RST),
      .bus (bus)
   );

   always #5 CLK = ~CLK;

   int n_cmp = 0;
   int n_err = 0;
   logic [16:0] exp_q [$];

   // Golden logistic step, bit-exact in Q2.16 / Q0.17
   function automatic logic [16:0] step(input logic [17:0] m, input logic [16:0] x);
      longint unsigned t, e;
      t = longint'(x) * (longint'(131072) - longint'(x));
      e = longint'(m) * (t >> 16);
      return 17'(e >> 17);
   endfunction

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic check(input string tag, input logic [35:0] obs, input logic [35:0] expv);
      n_cmp++;
      assert (obs === expv)
      else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
      end
   endtask

   // Read one lane through the registered port and compare to a constant
   task automatic read_const(input int lane, input logic [16:0] expv, input string tag);
      bus.rd_lane = LW'(lane);
      tick();
      check(tag, 36'(bus.rd_x), 36'(expv));
   endtask

   // Read all lanes and compare against scoreboard entries
   task automatic drain_lanes(input string tag);
      logic [16:0] e;
      for (int i = 0; i < LANES; i++) begin
         bus.rd_lane = LW'(i);
         tick();
         if (exp_q.size() == 0) begin
            check({tag, "_sb_empty"}, 36'd1, 36'd0);
         end else begin
            e = exp_q.pop_front();
            check($sformatf("%s_lane%0d", tag, i), 36'(bus.rd_x), 36'(e));
         end
      end
   endtask

   // Run one job; disturb_at (>=0) pulses start and changes operands mid-run
   task automatic run(input logic [17:0] m, input logic [8:0] t, input logic [16:0] b,
                      input int disturb_at, input string tag);
      logic [16:0] gx [LANES];
      int cyc;
      for (int i = 0; i < LANES; i++) gx[i] = 17'(b + 17'(i));
      for (int s = 0; s < int'(t); s++)
         for (int i = 0; i < LANES; i++) gx[i] = step(m, gx[i]);
      for (int i = 0; i < LANES; i++) exp_q.push_back(gx[i]);

      bus.mu = m; bus.times = t; bus.dzero_base = b; bus.start = 1'b1;
      tick();
      bus.start = 1'b0;
      check({tag, "_busy_set"}, 36'(bus.busy), 36'd1);
      check({tag, "_done_clr"}, 36'(bus.done), 36'd0);
      cyc = 0;
      while (!bus.done && cyc < 20000) begin
         if (cyc == disturb_at) begin
            bus.start = 1'b1;
            bus.mu = ~m; bus.times = t + 9'd3; bus.dzero_base = b ^ 17'h0F0F0;
         end
         tick();
         bus.start = 1'b0;
         cyc++;
      end
      check({tag, "_latency"}, 36'(cyc), 36'(1 + 2 * LANES * int'(t)));
      check({tag, "_busy_clr"}, 36'(bus.busy), 36'd0);
      check({tag, "_sweep"}, 36'(bus.sweep), 36'(t));
      tick();
      check({tag, "_idle_after"}, 36'({bus.busy, bus.done}), 36'b01);
   endtask

   initial begin
      RST = 1'b1;
      bus.start = 1'b0; bus.mu = '0; bus.times = '0; bus.dzero_base = '0; bus.rd_lane = '0;
      repeat (3) tick();
      check("rst_busy", 36'(bus.busy), 36'd0);
      check("rst_done", 36'(bus.done), 36'd0);
      check("rst_sweep", 36'(bus.sweep), 36'd0);
      check("rst_rdx", 36'(bus.rd_x), 36'd0);
      RST = 1'b0;
      tick();

      // times=0: load only, lanes wrap modulo 2^17
      run(18'h10000, 9'd0, 17'h1FFFC, -1, "t0");
      drain_lanes("t0");

      // mu=1.0, x0=0.5, one sweep -> 0.25
      run(18'h10000, 9'd1, 17'h10000, -1, "half");
      read_const(0, 17'h08000, "half_lane0");
      drain_lanes("half");

      // largest mu at the map peak: no overflow
      run(18'h3FFFF, 9'd1, 17'h10000, -1, "maxmu");
      read_const(0, 17'h1FFFF, "maxmu_lane0");
      drain_lanes("maxmu");

      // start and operand changes mid-run are ignored
      run(18'h3A000, 9'd3, 17'h04321, 5, "restart");
      drain_lanes("restart");

      // start on the very edge that completes the run is ignored
      run(18'h2C000, 9'd2, 17'h12345, 2 * LANES * 2, "done_edge");
      drain_lanes("done_edge");

      // reset mid-run aborts and clears everything
      bus.mu = 18'h38000; bus.times = 9'd9; bus.dzero_base = 17'h0ABCD; bus.start = 1'b1;
      tick();
      bus.start = 1'b0;
      repeat (40) tick();
      RST = 1'b1;
      tick();
      RST = 1'b0;
      check("abort_busy", 36'(bus.busy), 36'd0);
      check("abort_done", 36'(bus.done), 36'd0);
      check("abort_sweep", 36'(bus.sweep), 36'd0);
      for (int i = 0; i < LANES; i++) exp_q.push_back(17'd0);
      drain_lanes("abort");
      run(18'h31000, 9'd4, 17'h09876, -1, "after_abort");
      drain_lanes("after_abort");

      // long run with random operands
      run(18'($urandom_range(0, 18'h3FFFF)), 9'h1FF, 17'($urandom_range(0, 17'h1FFFF)), -1, "long");
      drain_lanes("long");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
